// File: rtl/vsdma_axi_pkg.sv
// Shared types and helpers for the VSDMA AXI responder.
package vsdma_axi_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Bytes carried by one data beat.
    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    // Right shift that turns a byte address into a word index.
    function automatic int addr_shift(input int data_width);
        return clog2(data_width / 8);
    endfunction

    localparam int C_DFLT_DATA_WIDTH = 256;
    localparam int C_DFLT_BYTES      = bytes_per_beat(C_DFLT_DATA_WIDTH);
    localparam int C_DFLT_SHIFT      = addr_shift(C_DFLT_DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD       = 2'd2,
        S_RD_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/vsdma_axi_rdbuf.sv
// Two-entry read-data FIFO carrying {last, data}; its entries double as the
// RAM read register, so a beat written here is visible on R the next cycle.
module vsdma_axi_rdbuf
    import vsdma_axi_pkg::*;
#(
    parameter int DW = C_DFLT_DATA_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [1:0]    o_count
);
    logic [DW:0] r_ent [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    // Entry storage, pointers and occupancy; reset flushes everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) r_ent[i] <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_ent[r_wptr] <= {i_last, i_data};
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid           = (r_count != 2'd0);
    assign {o_last, o_data}  = r_ent[r_rptr];
    assign o_count           = r_count;
endmodule

// File: rtl/vsdma_axi_responder.sv
// RAM-backed AXI responder for the video-stream DMA: AW/W/AR/R, INCR only,
// one burst at a time, round-robin between write and read address channels.
module vsdma_axi_responder
    import vsdma_axi_pkg::*;
#(
    parameter int S_AXI_ID_WIDTH   = 4,
    parameter int S_AXI_ADDR_WIDTH = 28,
    parameter int S_AXI_DATA_WIDTH = 256,
    parameter int MEM_DEPTH        = 1024
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_WID,
    input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          busy,
    output logic                          wlast_err
);
    localparam int NBYTES = bytes_per_beat(S_AXI_DATA_WIDTH);
    localparam int SHIFT  = addr_shift(S_AXI_DATA_WIDTH);
    localparam int IW     = clog2(MEM_DEPTH);

    state_t                        r_state, w_state_nxt;
    logic                          r_wr_last;   // 1: write won the last grant
    logic [IW-1:0]                 r_idx;
    logic [8:0]                    r_cnt;       // beats left to write / issue
    logic [S_AXI_ID_WIDTH-1:0]     r_rid;
    logic                          r_wlast_err;
    logic [S_AXI_DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                          w_grant_wr;
    logic                          w_aw_hs;
    logic                          w_ar_hs;
    logic                          w_wbeat;
    logic                          w_issue;
    logic                          w_cnt_one;
    logic                          w_rvalid;
    logic                          w_rlast;
    logic                          w_pop;
    logic [1:0]                    w_buf_cnt;
    logic [IW-1:0]                 w_aw_idx;
    logic [IW-1:0]                 w_ar_idx;
    logic                          w_unused_ok;

    assign w_grant_wr  = ~r_wr_last;
    assign w_cnt_one   = (r_cnt == 9'd1);
    assign w_wbeat     = (r_state == S_WR) & S_AXI_WVALID;
    assign w_pop       = w_rvalid & S_AXI_RREADY;
    // Truncation to IW bits gives the silent wrap at the top of RAM.
    assign w_aw_idx    = IW'(S_AXI_AWADDR >> SHIFT);
    assign w_ar_idx    = IW'(S_AXI_ARADDR >> SHIFT);
    assign w_unused_ok = ^{S_AXI_AWID, S_AXI_WID};

    // Next state, address-channel arbitration and per-state strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_aw_hs      = 1'b0;
        w_ar_hs      = 1'b0;
        w_issue      = 1'b0;
        S_AXI_WREADY = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_aw_hs = ~S_AXI_ARESET & S_AXI_AWVALID & (~S_AXI_ARVALID | w_grant_wr);
                w_ar_hs = ~S_AXI_ARESET & S_AXI_ARVALID & (~S_AXI_AWVALID | ~w_grant_wr);
                if (w_aw_hs)      w_state_nxt = S_WR;
                else if (w_ar_hs) w_state_nxt = S_RD;
            end
            S_WR: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_cnt_one) w_state_nxt = S_IDLE;
            end
            S_RD: begin
                // FIFO slots are the only place a read can be outstanding.
                w_issue = (w_buf_cnt < 2'd2);
                if (w_issue && w_cnt_one) w_state_nxt = S_RD_DRAIN;
            end
            S_RD_DRAIN: begin
                if (w_pop && w_rlast) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = w_aw_hs;
    assign S_AXI_ARREADY = w_ar_hs;

    // State register plus burst bookkeeping (index, count, ID, error flag).
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state     <= S_IDLE;
            r_wr_last   <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rid       <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_idx     <= w_aw_idx;
                r_cnt     <= {1'b0, S_AXI_AWLEN} + 9'd1;
                r_wr_last <= 1'b1;
            end else if (w_ar_hs) begin
                r_idx     <= w_ar_idx;
                r_cnt     <= {1'b0, S_AXI_ARLEN} + 9'd1;
                r_rid     <= S_AXI_ARID;
                r_wr_last <= 1'b0;
            end else if (w_wbeat || w_issue) begin
                r_idx <= r_idx + IW'(1);
                r_cnt <= r_cnt - 9'd1;
            end
            if (w_wbeat && (S_AXI_WLAST != w_cnt_one)) r_wlast_err <= 1'b1;
        end
    end

    // Byte-masked RAM write; contents survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_wbeat) begin
            for (int b = 0; b < NBYTES; b++)
                if (S_AXI_WSTRB[b]) r_mem[r_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
    end

    vsdma_axi_rdbuf #(.DW(S_AXI_DATA_WIDTH)) u_rdbuf (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_push  (w_issue),
        .i_data  (r_mem[r_idx]),
        .i_last  (w_cnt_one),
        .i_pop   (w_pop),
        .o_valid (w_rvalid),
        .o_data  (S_AXI_RDATA),
        .o_last  (w_rlast),
        .o_count (w_buf_cnt)
    );

    assign S_AXI_RVALID = w_rvalid;
    assign S_AXI_RLAST  = w_rlast;
    assign S_AXI_RID    = r_rid;
    assign busy         = (r_state != S_IDLE);
    assign wlast_err    = r_wlast_err;
endmodule
